// File: rtl/switch_unit.sv
// switch_unit: packet-atomic round-robin N:1 switch. Drains the heads of
// num_inports upstream queues into one downstream queue with zero latency and
// no internal buffering. Once a non-tail flit is forwarded, the grant stays on
// that inport until its tail flit has been forwarded.
module switch_unit #(
    parameter int data_width  = 32,
    parameter int num_inports = 4,
    parameter int sel_width   = (num_inports == 1) ? 1 : $clog2(num_inports)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [num_inports-1:0]            in_deq_rdy,
    input  logic [num_inports*data_width-1:0] in_deq_msg,
    output logic [num_inports-1:0]            in_deq_en,
    input  logic                              out_enq_rdy,
    output logic                              out_enq_en,
    output logic [data_width-1:0]             out_enq_msg,
    output logic [sel_width-1:0]              out_sel
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } fsm_t;

    fsm_t                  fsm;
    logic [sel_width-1:0]  prio_ptr;
    logic [sel_width-1:0]  lock_idx;

    logic                  grant_valid;
    logic [sel_width-1:0]  grant_idx;
    logic [sel_width-1:0]  mux_idx;
    logic [data_width-1:0] sel_msg;
    logic                  xfer;
    logic                  tail;

    // Successor of an inport index; explicit compare so non-power-of-two
    // inport counts wrap to 0 instead of into an unused index.
    function automatic logic [sel_width-1:0] next_idx(input logic [sel_width-1:0] idx);
        return (idx == sel_width'(num_inports - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Pick the granted inport: locked inport only, or a rotating search from prio_ptr.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (fsm == LOCKED) begin
            grant_valid = in_deq_rdy[lock_idx];
            grant_idx   = lock_idx;
        end else begin
            for (int k = 0; k < num_inports; k++) begin
                idx = int'(prio_ptr) + k;
                if (idx >= num_inports) begin
                    idx = idx - num_inports;
                end
                if (!grant_valid && in_deq_rdy[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = sel_width'(idx);
                end
            end
        end
    end

    // Forward the granted flit and strobe both queues when a transfer happens.
    always_comb begin
        // While in reset the mux is steered to inport 0 so the data path stays clean.
        mux_idx     = reset ? grant_idx : '0;
        sel_msg     = in_deq_msg[int'(mux_idx)*data_width +: data_width];
        tail        = sel_msg[data_width-1];
        xfer        = reset && grant_valid && out_enq_rdy;
        out_enq_en  = xfer;
        out_enq_msg = sel_msg;
        out_sel     = mux_idx;
        in_deq_en   = '0;
        if (xfer) begin
            in_deq_en[grant_idx] = 1'b1;
        end
    end

    // Track packet boundaries; priority advances only on completed packets.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            fsm      <= IDLE;
            prio_ptr <= '0;
            lock_idx <= '0;
        end else if (xfer) begin
            case (fsm)
                IDLE: begin
                    if (!tail) begin
                        fsm      <= LOCKED;
                        lock_idx <= grant_idx;
                    end else begin
                        prio_ptr <= next_idx(grant_idx);
                    end
                end
                LOCKED: begin
                    if (tail) begin
                        fsm      <= IDLE;
                        prio_ptr <= next_idx(lock_idx);
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_unit.sv
// Self-checking bench for switch_unit: a 4-inport instance driven from a
// vector table through a scoreboard, plus a 3-inport instance for wrap-around.
module tb_switch_unit;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int N3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-inport DUT signals
    logic          reset;
    logic [N-1:0]  in_deq_rdy;
    logic [N*DW-1:0] in_deq_msg;
    logic [N-1:0]  in_deq_en;
    logic          out_enq_rdy;
    logic          out_enq_en;
    logic [DW-1:0] out_enq_msg;
    logic [1:0]    out_sel;

    // 3-inport DUT signals
    logic           reset3;
    logic [N3-1:0]  rdy3;
    logic [N3*DW-1:0] msg3;
    logic [N3-1:0]  deq_en3;
    logic           ordy3;
    logic           en3;
    logic [DW-1:0]  omsg3;
    logic [1:0]     sel3;

    switch_unit #(.data_width(DW), .num_inports(N)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_deq_rdy  (in_deq_rdy),
        .in_deq_msg  (in_deq_msg),
        .in_deq_en   (in_deq_en),
        .out_enq_rdy (out_enq_rdy),
        .out_enq_en  (out_enq_en),
        .out_enq_msg (out_enq_msg),
        .out_sel     (out_sel)
    );

    switch_unit #(.data_width(DW), .num_inports(N3)) u_dut3 (
        .clk         (clk),
        .reset       (reset3),
        .in_deq_rdy  (rdy3),
        .in_deq_msg  (msg3),
        .in_deq_en   (deq_en3),
        .out_enq_rdy (ordy3),
        .out_enq_en  (en3),
        .out_enq_msg (omsg3),
        .out_sel     (sel3)
    );

    typedef struct {
        logic       rst;
        logic [3:0] rdy;
        logic [3:0] tails;
        logic       ordy;
        logic       exp_en;
        logic [1:0] exp_sel;
        string      name;
    } vec_t;

    typedef struct {
        string      name;
        logic       en;
        logic [3:0] deq;
        logic [1:0] sel;
        logic [DW-1:0] msg;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   seq[N];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] rdy, input logic [3:0] tails,
                       input logic ordy, input logic en, input logic [1:0] sel, input string name);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.tails = tails; v.ordy = ordy;
        v.exp_en = en; v.exp_sel = sel; v.name = name;
        tbl.push_back(v);
    endtask

    function automatic logic [DW-1:0] make_msg(input int i, input logic tail);
        return {tail, 7'h0, 8'(i), 16'(seq[i])};
    endfunction

    // Drive one table row and push what the DUT must show during that cycle.
    task automatic step(input vec_t v);
        exp_t e;
        reset       = v.rst;
        out_enq_rdy = v.ordy;
        in_deq_rdy  = v.rdy;
        for (int i = 0; i < N; i++) begin
            in_deq_msg[i*DW +: DW] = make_msg(i, v.tails[i]);
        end
        e.name = v.name;
        e.en   = v.exp_en;
        e.sel  = v.exp_sel;
        e.deq  = '0;
        e.msg  = '0;
        if (v.exp_en) begin
            e.deq[v.exp_sel] = 1'b1;
            e.msg = make_msg(int'(v.exp_sel), v.tails[v.exp_sel]);
            seq[v.exp_sel]++;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare outputs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, " en"}, DW'(out_enq_en), DW'(e.en));
            check({e.name, " deq_en"}, DW'(in_deq_en), DW'(e.deq));
            if (e.en) begin
                check({e.name, " sel"}, DW'(out_sel), DW'(e.sel));
                check({e.name, " msg"}, out_enq_msg, e.msg);
            end
        end
    end

    // Hand-written step for the 3-inport instance with direct checks.
    task automatic step3(input logic rst, input logic [2:0] rdy, input logic [2:0] tails,
                         input logic en, input logic [1:0] sel, input string name);
        logic [2:0] deq;
        reset3 = rst;
        ordy3  = 1'b1;
        rdy3   = rdy;
        for (int i = 0; i < N3; i++) begin
            msg3[i*DW +: DW] = {tails[i], 7'h0, 8'(i), 16'h00AA};
        end
        deq = '0;
        if (en) deq[sel] = 1'b1;
        @(negedge clk);
        check({name, " en"}, DW'(en3), DW'(en));
        check({name, " deq_en"}, DW'(deq_en3), DW'(deq));
        if (en) begin
            check({name, " sel"}, DW'(sel3), DW'(sel));
            check({name, " msg"}, omsg3, {tails[sel], 7'h0, 8'(sel), 16'h00AA});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; in_deq_rdy = '0; in_deq_msg = '0; out_enq_rdy = 1'b0;
        reset3 = 1'b0; rdy3 = '0; msg3 = '0; ordy3 = 1'b0;
        for (int i = 0; i < N; i++) seq[i] = 0;

        // Reset, then round-robin single flits: 0,1,2,3,0,1 (prio ends at 2)
        add(0, 4'b1111, 4'b1111, 1, 0, 0, "rst0");
        add(0, 4'b1111, 4'b1111, 1, 0, 0, "rst1");
        add(1, 4'b1111, 4'b1111, 1, 1, 0, "rr0");
        add(1, 4'b1111, 4'b1111, 1, 1, 1, "rr1");
        add(1, 4'b1111, 4'b1111, 1, 1, 2, "rr2");
        add(1, 4'b1111, 4'b1111, 1, 1, 3, "rr3");
        add(1, 4'b1111, 4'b1111, 1, 1, 0, "rr4");
        add(1, 4'b1111, 4'b1111, 1, 1, 1, "rr5");
        // Only inport 0 ready: grant 0, prio -> 1
        add(1, 4'b0001, 4'b1111, 1, 1, 0, "solo0");
        // Packet lock on inport 1 with a 2-cycle bubble; inport 2 always ready
        add(1, 4'b0110, 4'b0100, 1, 1, 1, "pkt_h");
        add(1, 4'b0110, 4'b0100, 1, 1, 1, "pkt_b");
        add(1, 4'b0100, 4'b0100, 1, 0, 0, "bubble0");
        add(1, 4'b0100, 4'b0100, 1, 0, 0, "bubble1");
        add(1, 4'b0110, 4'b0110, 1, 1, 1, "pkt_t");
        add(1, 4'b0110, 4'b0110, 1, 1, 2, "after_pkt");
        // Backpressure mid-packet on inport 3 (prio is 3)
        add(1, 4'b1000, 4'b0000, 1, 1, 3, "bp_h");
        for (int i = 0; i < 5; i++) add(1, 4'b1111, 4'b0000, 0, 0, 0, "bp_stall");
        add(1, 4'b1111, 4'b0000, 1, 1, 3, "bp_b");
        add(1, 4'b1111, 4'b1000, 1, 1, 3, "bp_t");
        add(1, 4'b1111, 4'b1111, 1, 1, 0, "bp_next");
        // Reset mid-packet: lock on inport 3, reset, order restarts at 0
        add(1, 4'b1000, 4'b0000, 1, 1, 3, "mid_h");
        add(1, 4'b1000, 4'b0000, 1, 1, 3, "mid_b");
        add(0, 4'b1111, 4'b1111, 1, 0, 0, "mid_rst");
        add(1, 4'b1111, 4'b1111, 1, 1, 0, "mid_rr0");
        add(1, 4'b1111, 4'b1111, 1, 1, 1, "mid_rr1");

        @(posedge clk);
        #1;
        foreach (tbl[i]) step(tbl[i]);
        @(negedge clk);
        check("sb_drained", DW'(sb.size()), '0);

        // Wrap on a non-power-of-two switch
        step3(0, 3'b111, 3'b111, 0, 0, "w_rst");
        step3(1, 3'b100, 3'b111, 1, 2, "w_only2");
        step3(1, 3'b011, 3'b111, 1, 0, "w_wrap");
        step3(1, 3'b111, 3'b111, 1, 1, "w_next");
        step3(1, 3'b111, 3'b111, 1, 2, "w_next2");
        step3(1, 3'b111, 3'b111, 1, 0, "w_wrap2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
